// File: rtl/arcade_input_pkg.sv
// Shared types and timing constants for the arcade input conditioning blocks.
// Defaults assume a 24.576 MHz system clock.
package arcade_input_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_state_e;

   localparam int unsigned DEBOUNCE_5MS_24M = 122880;
   localparam int unsigned PULSE_100MS_24M  = 2457600;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser, stability debounce and one-cycle rising-edge strobe
// for a raw push button.
module input_debounce
   import arcade_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_5MS_24M
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic rise
);

   localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // The level only flips after the synchronised input has disagreed with it
   // for DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync2;
            rise  <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/coin_pulse_shaper.sv
// Turns debounced coin presses into fixed-width, spaced, active-low coin
// pulses, queueing presses that arrive faster than they can be emitted.
module coin_pulse_shaper
   import arcade_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_5MS_24M,
   parameter int unsigned PULSE_CYC    = PULSE_100MS_24M,
   parameter int unsigned GAP_CYC      = PULSE_100MS_24M,
   parameter int unsigned QDEPTH_W     = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin_raw,
   input  logic                pause,
   output logic                coin_n,
   output logic                busy,
   output logic [QDEPTH_W-1:0] pending,
   output logic                overflow
);

   localparam int unsigned        TMR_MAX    = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int unsigned        TMR_W      = cnt_width(TMR_MAX);
   localparam logic [TMR_W-1:0]   PULSE_LAST = TMR_W'(PULSE_CYC - 1);
   localparam logic [TMR_W-1:0]   GAP_LAST   = TMR_W'(GAP_CYC - 1);
   localparam logic [QDEPTH_W-1:0] Q_MAX     = '1;

   coin_state_e         state;
   coin_state_e         state_nxt;
   logic [TMR_W-1:0]    timer;
   logic [TMR_W-1:0]    timer_nxt;
   logic [QDEPTH_W-1:0] pending_nxt;
   logic                overflow_nxt;
   logic                deq;
   logic                press;

   input_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (coin_raw),
      .rise  (press)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         timer    <= '0;
         pending  <= '0;
         overflow <= 1'b0;
         coin_n   <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         pending  <= pending_nxt;
         overflow <= overflow_nxt;
         coin_n   <= (state_nxt != PULSE);
         busy     <= (state_nxt != IDLE) || (pending_nxt != '0);
      end
   end

   // Pause freezes state and timer, so an interrupted pulse keeps its remaining width.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      deq       = 1'b0;
      if (!pause) begin
         case (state)
            IDLE: begin
               if (pending != '0) begin
                  state_nxt = PULSE;
                  timer_nxt = '0;
                  deq       = 1'b1;
               end
            end
            PULSE: begin
               if (timer == PULSE_LAST) begin
                  state_nxt = GAP;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + TMR_W'(1);
               end
            end
            GAP: begin
               if (timer == GAP_LAST) begin
                  timer_nxt = '0;
                  if (pending != '0) begin
                     state_nxt = PULSE;
                     deq       = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  timer_nxt = timer + TMR_W'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end
         endcase
      end
   end

   // Saturating press queue; a simultaneous press and dequeue cancel out.
   always_comb begin
      pending_nxt  = pending;
      overflow_nxt = overflow;
      if (press && !deq) begin
         if (pending == Q_MAX) begin
            overflow_nxt = 1'b1;
         end else begin
            pending_nxt = pending + QDEPTH_W'(1);
         end
      end else if (deq && !press) begin
         pending_nxt = pending - QDEPTH_W'(1);
      end
   end

endmodule
